// File: rtl/rsp_s2_prep_pg_seq_ctrl.sv
// ---------------------------------------------------------------------------
// rsp_s2_prep_pg_seq_ctrl
//
// Control sequencer for the phase-generation (twiddle select) datapath.
// After reset it loads TWIDDLE_NUM twiddle words into the datapath twiddle
// RAM. It then serves symbol requests. For each symbol it issues one start
// pulse, waits START_GAP idle cycles, and then issues DATA_NUM data-valid
// strobes, with last on the final strobe. Strobes pause while i_hold is high.
// A PIPE_LAT-deep delay line gives a phase-valid/last pair that lines up
// with the datapath phase output.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   i_cfg_valid/o_cfg_ready/i_cfg_data/i_cfg_last
//                       twiddle load stream (word taken on valid & ready)
//   i_reload            re-enter the load phase (honoured only in READY)
//   i_sym_req/o_sym_ack symbol request (level) / accept pulse
//   i_entry_select      entry for the requested symbol, latched on accept
//   i_hold              downstream backpressure, pauses data-valid strobes
//   o_ram_*             twiddle RAM port (write during load, read mode
//                       while a symbol runs)
//   o_entry_select      latched entry select
//   o_start, o_data_valid, o_data_last
//                       datapath control strobes
//   o_phase_valid, o_phase_last
//                       data-valid/last delayed by PIPE_LAT
//   o_done              symbol fully drained (one-cycle pulse)
//   o_load_done         a valid twiddle table is present
//   o_err_load          sticky load-length mismatch
// ---------------------------------------------------------------------------
module rsp_s2_prep_pg_seq_ctrl #(
    parameter int TWIDDLE_NUM     = 136,
    parameter int DATA_NUM        = 1024,
    parameter int RAM_DATA_WIDTH  = 64,
    parameter int RAM_ADDR_WIDTH  = 8,
    parameter int ENTRY_SEL_WIDTH = 6,
    parameter int START_GAP       = 2,
    parameter int PIPE_LAT        = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_cfg_valid,
    output logic                       o_cfg_ready,
    input  logic [RAM_DATA_WIDTH-1:0]  i_cfg_data,
    input  logic                       i_cfg_last,
    input  logic                       i_reload,
    input  logic                       i_sym_req,
    input  logic [ENTRY_SEL_WIDTH-1:0] i_entry_select,
    output logic                       o_sym_ack,
    input  logic                       i_hold,
    output logic                       o_ram_ena,
    output logic                       o_ram_wena,
    output logic [RAM_ADDR_WIDTH-1:0]  o_ram_addra,
    output logic [RAM_DATA_WIDTH-1:0]  o_ram_dina,
    output logic [ENTRY_SEL_WIDTH-1:0] o_entry_select,
    output logic                       o_start,
    output logic                       o_data_valid,
    output logic                       o_data_last,
    output logic                       o_phase_valid,
    output logic                       o_phase_last,
    output logic                       o_done,
    output logic                       o_load_done,
    output logic                       o_err_load
);

    localparam int TW_CW  = $clog2(TWIDDLE_NUM) + 1;
    localparam int DN_CW  = $clog2(DATA_NUM) + 1;
    localparam int GAP_CW = $clog2(START_GAP + 1) + 1;
    localparam int PL_CW  = $clog2(PIPE_LAT + 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READY,
        S_START,
        S_GAP,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t                    state;
    logic [TW_CW-1:0]          load_cnt;
    logic [DN_CW-1:0]          data_cnt;
    logic [GAP_CW-1:0]         gap_cnt;
    logic [PL_CW-1:0]          drain_cnt;
    logic [PIPE_LAT-1:0]       pv_sr;
    logic [PIPE_LAT-1:0]       pl_sr;

    logic word_acc;
    logic word_final;
    logic strobe;
    logic strobe_last;

    // o_cfg_ready is high exactly while in LOAD, so this is the handshake.
    assign word_acc    = o_cfg_ready && i_cfg_valid;
    assign word_final  = (load_cnt == TW_CW'(TWIDDLE_NUM - 1));

    // The strobe is a gate on the registered RUN state, not a register.
    // This keeps i_hold effective in the same cycle it is raised.
    assign strobe      = (state == S_RUN) && !i_hold;
    assign strobe_last = strobe && (data_cnt == DN_CW'(DATA_NUM - 1));

    assign o_data_valid  = strobe;
    assign o_data_last   = strobe_last;
    assign o_phase_valid = pv_sr[PIPE_LAT-1];
    assign o_phase_last  = pl_sr[PIPE_LAT-1];
    // The final phase-last of a symbol falls in the last DRAIN cycle.
    assign o_done        = pl_sr[PIPE_LAT-1] && (state == S_DRAIN);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side reads the value from before the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            load_cnt       <= '0;
            data_cnt       <= '0;
            gap_cnt        <= '0;
            drain_cnt      <= '0;
            o_cfg_ready    <= 1'b0;
            o_sym_ack      <= 1'b0;
            o_start        <= 1'b0;
            o_ram_ena      <= 1'b0;
            o_ram_wena     <= 1'b0;
            o_ram_addra    <= '0;
            o_ram_dina     <= '0;
            o_entry_select <= '0;
            o_load_done    <= 1'b0;
            o_err_load     <= 1'b0;
        end else begin
            o_sym_ack <= 1'b0;
            o_start   <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    state       <= S_LOAD;
                    o_cfg_ready <= 1'b1;
                    load_cnt    <= '0;
                end

                S_LOAD: begin
                    // The write port follows the accepted word by one cycle.
                    o_ram_ena  <= word_acc;
                    o_ram_wena <= word_acc;
                    if (word_acc) begin
                        o_ram_addra <= RAM_ADDR_WIDTH'(load_cnt);
                        o_ram_dina  <= i_cfg_data;
                        if (word_final || i_cfg_last) begin
                            load_cnt <= '0;
                            if (word_final && i_cfg_last) begin
                                // A complete table replaces any failed attempt.
                                o_load_done <= 1'b1;
                                o_err_load  <= 1'b0;
                                o_cfg_ready <= 1'b0;
                                state       <= S_READY;
                            end else begin
                                // Length mismatch: restart the table at index 0.
                                o_load_done <= 1'b0;
                                o_err_load  <= 1'b1;
                            end
                        end else begin
                            load_cnt <= load_cnt + TW_CW'(1);
                        end
                    end
                end

                S_READY: begin
                    o_ram_ena  <= 1'b0;
                    o_ram_wena <= 1'b0;
                    if (i_reload) begin
                        // Reload has priority over a pending request.
                        state       <= S_LOAD;
                        o_cfg_ready <= 1'b1;
                        o_load_done <= 1'b0;
                        o_err_load  <= 1'b0;
                        load_cnt    <= '0;
                    end else if (i_sym_req) begin
                        o_sym_ack      <= 1'b1;
                        o_start        <= 1'b1;
                        o_entry_select <= i_entry_select;
                        o_ram_ena      <= 1'b1;  // read mode until back in READY
                        state          <= S_START;
                    end
                end

                S_START: begin
                    data_cnt <= '0;
                    gap_cnt  <= '0;
                    state    <= (START_GAP == 0) ? S_RUN : S_GAP;
                end

                S_GAP: begin
                    if (gap_cnt == GAP_CW'(START_GAP - 1)) begin
                        state <= S_RUN;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_CW'(1);
                    end
                end

                S_RUN: begin
                    if (strobe_last) begin
                        drain_cnt <= '0;
                        state     <= S_DRAIN;
                    end else if (strobe) begin
                        data_cnt <= data_cnt + DN_CW'(1);
                    end
                end

                S_DRAIN: begin
                    if (drain_cnt == PL_CW'(PIPE_LAT - 1)) begin
                        o_ram_ena <= 1'b0;
                        state     <= S_READY;
                    end else begin
                        drain_cnt <= drain_cnt + PL_CW'(1);
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // Phase-valid/last delay line. It runs regardless of state, so it follows
    // the datapath pipeline exactly.
    // NOTE: the delay line is reset on purpose. A mid-symbol reset must not
    // let stale phase strobes leak out after the reset is released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pv_sr <= '0;
            pl_sr <= '0;
        end else begin
            pv_sr[0] <= strobe;
            pl_sr[0] <= strobe_last;
            for (int i = 1; i < PIPE_LAT; i++) begin
                pv_sr[i] <= pv_sr[i-1];
                pl_sr[i] <= pl_sr[i-1];
            end
        end
    end

endmodule

// File: tb/tb_rsp_s2_prep_pg_seq_ctrl.sv
// ---------------------------------------------------------------------------
// Self-checking bench for rsp_s2_prep_pg_seq_ctrl.
// Load scenarios come from a table of {stimulus, expected result} records.
// Symbols are checked against a timeline the bench builds from its own hold
// pattern: start and ack one cycle after the request, then START_GAP idle
// cycles, then the first DATA_NUM un-held cycles strobe.
// ---------------------------------------------------------------------------
module tb_rsp_s2_prep_pg_seq_ctrl;

    localparam int TWIDDLE_NUM     = 136;
    localparam int DATA_NUM        = 1024;
    localparam int RAM_DATA_WIDTH  = 64;
    localparam int RAM_ADDR_WIDTH  = 8;
    localparam int ENTRY_SEL_WIDTH = 6;
    localparam int START_GAP       = 2;
    localparam int PIPE_LAT        = 6;

    // Offsets inside a symbol: request sampled at 0, ack/start at 1,
    // START_GAP idle cycles, first possible strobe after that.
    localparam int FIRST_STROBE_OFF = 2 + START_GAP;
    localparam int HOLD_SPAN        = 4096;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       i_cfg_valid = 1'b0;
    logic [RAM_DATA_WIDTH-1:0]  i_cfg_data = '0;
    logic                       i_cfg_last = 1'b0;
    logic                       i_reload = 1'b0;
    logic                       i_sym_req = 1'b0;
    logic [ENTRY_SEL_WIDTH-1:0] i_entry_select = '0;
    logic                       i_hold = 1'b0;

    logic                       o_cfg_ready;
    logic                       o_sym_ack;
    logic                       o_ram_ena;
    logic                       o_ram_wena;
    logic [RAM_ADDR_WIDTH-1:0]  o_ram_addra;
    logic [RAM_DATA_WIDTH-1:0]  o_ram_dina;
    logic [ENTRY_SEL_WIDTH-1:0] o_entry_select;
    logic                       o_start;
    logic                       o_data_valid;
    logic                       o_data_last;
    logic                       o_phase_valid;
    logic                       o_phase_last;
    logic                       o_done;
    logic                       o_load_done;
    logic                       o_err_load;

    rsp_s2_prep_pg_seq_ctrl #(
        .TWIDDLE_NUM    (TWIDDLE_NUM),
        .DATA_NUM       (DATA_NUM),
        .RAM_DATA_WIDTH (RAM_DATA_WIDTH),
        .RAM_ADDR_WIDTH (RAM_ADDR_WIDTH),
        .ENTRY_SEL_WIDTH(ENTRY_SEL_WIDTH),
        .START_GAP      (START_GAP),
        .PIPE_LAT       (PIPE_LAT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_cfg_valid   (i_cfg_valid),
        .o_cfg_ready   (o_cfg_ready),
        .i_cfg_data    (i_cfg_data),
        .i_cfg_last    (i_cfg_last),
        .i_reload      (i_reload),
        .i_sym_req     (i_sym_req),
        .i_entry_select(i_entry_select),
        .o_sym_ack     (o_sym_ack),
        .i_hold        (i_hold),
        .o_ram_ena     (o_ram_ena),
        .o_ram_wena    (o_ram_wena),
        .o_ram_addra   (o_ram_addra),
        .o_ram_dina    (o_ram_dina),
        .o_entry_select(o_entry_select),
        .o_start       (o_start),
        .o_data_valid  (o_data_valid),
        .o_data_last   (o_data_last),
        .o_phase_valid (o_phase_valid),
        .o_phase_last  (o_phase_last),
        .o_done        (o_done),
        .o_load_done   (o_load_done),
        .o_err_load    (o_err_load)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int n_words;
        int last_idx;     // index carrying i_cfg_last, -1 for none
        bit pre_reload;   // starts from READY, so pulse i_reload first
        bit gaps;         // random idle cycles on i_cfg_valid
        bit exp_done;
        bit exp_err;
    } load_vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    function automatic int first_or_neg(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    function automatic logic [63:0] ctrl_outs();
        return 64'({o_cfg_ready, o_sym_ack, o_ram_ena, o_ram_wena, o_start, o_data_valid,
                    o_data_last, o_phase_valid, o_phase_last, o_done, o_load_done, o_err_load,
                    o_entry_select, o_ram_addra});
    endfunction

    // One load attempt that starts with the word counter at 0. It returns at
    // the drive point of the cycle after the one where the result is visible.
    task automatic load_table(input int n, input int last_idx, input bit pre_reload,
                              input bit gaps, input bit exp_done, input bit exp_err,
                              input string tag);
        logic [RAM_DATA_WIDTH-1:0] words[$];
        int sent = 0;
        int cyc = 0;
        int bad_ready = 0;
        int acks = 0;
        int nwr = 0;
        int bad_wr = -1;
        bit v;
        if (pre_reload) begin
            i_reload    = 1'b1;
            i_cfg_valid = 1'b0;
            i_cfg_last  = 1'b0;
            to_sample();
            if (o_sym_ack === 1'b1) acks++;
            if (o_ram_wena === 1'b1) nwr++;
            to_drive();
            i_reload = 1'b0;
        end
        while (sent < n) begin
            v = gaps ? ($urandom_range(3, 0) != 0) : 1'b1;
            i_cfg_valid = v;
            i_cfg_data  = {$urandom, $urandom};
            i_cfg_last  = v && (sent == last_idx);
            to_sample();
            if (cyc == 0 && pre_reload) begin
                check({tag, "_reload_clears_done"}, 64'(o_load_done), 0);
                check({tag, "_reload_clears_err"}, 64'(o_err_load), 0);
            end
            if (o_cfg_ready !== 1'b1) bad_ready++;
            if (o_sym_ack === 1'b1) acks++;
            if (o_ram_ena === 1'b1 && o_ram_wena === 1'b1) begin
                if (bad_wr < 0 && (nwr >= words.size() || o_ram_addra !== RAM_ADDR_WIDTH'(nwr)
                                   || o_ram_dina !== words[nwr])) bad_wr = nwr;
                nwr++;
            end
            if (v) begin
                words.push_back(i_cfg_data);
                sent++;
            end
            cyc++;
            to_drive();
        end
        i_cfg_valid = 1'b0;
        i_cfg_last  = 1'b0;
        to_sample();
        if (o_sym_ack === 1'b1) acks++;
        if (o_ram_ena === 1'b1 && o_ram_wena === 1'b1) begin
            if (bad_wr < 0 && (nwr >= words.size() || o_ram_addra !== RAM_ADDR_WIDTH'(nwr)
                               || o_ram_dina !== words[nwr])) bad_wr = nwr;
            nwr++;
        end
        check({tag, "_ready_during_load"}, 64'(bad_ready), 0);
        check({tag, "_write_count"}, 64'(nwr), 64'(n));
        check({tag, "_first_bad_write"}, 64'(bad_wr), -64'sd1);
        check({tag, "_load_done"}, 64'(o_load_done), 64'(exp_done));
        check({tag, "_err_load"}, 64'(o_err_load), 64'(exp_err));
        check({tag, "_ready_after"}, 64'(o_cfg_ready), 64'(!exp_done));
        check({tag, "_no_ack_in_load"}, 64'(acks), 0);
        to_drive();
    endtask

    // One symbol starting in READY. first_off = 1 means the request was
    // already sampled in READY in the cycle just before this task started.
    // hold_mode: 0 no hold, 1 ten held cycles at strobe 500, 2 random holds
    // plus an ignored i_reload pulse mid-run.
    task automatic run_symbol(input logic [ENTRY_SEL_WIDTH-1:0] entry, input int first_off,
                              input int hold_mode, input string tag);
        bit hold_pat[HOLD_SPAN];
        int exp_strobe[$];
        int got_strobe[$], got_last[$], got_pv[$], got_pl[$], got_done[$], got_start[$], got_ack[$];
        int n = 0;
        int reload_off = -1;
        int exp_last, exp_done;
        int bad_ena = 0, bad_wena = 0, bad_entry = 0, bad_ready = 0;
        int bad_seq = -1, bad_pv = -1;
        bit exp_ena;
        for (int i = 0; i < HOLD_SPAN; i++) hold_pat[i] = 1'b0;
        if (hold_mode == 1)
            for (int i = 0; i < 10; i++) hold_pat[FIRST_STROBE_OFF + 500 + i] = 1'b1;
        if (hold_mode == 2)
            for (int i = 0; i < 1400; i++) hold_pat[i] = ($urandom_range(9, 0) == 0);

        // Reference: strobes land on the first DATA_NUM un-held cycles.
        for (int off = FIRST_STROBE_OFF; n < DATA_NUM; off++) begin
            if (!hold_pat[off]) begin
                exp_strobe.push_back(off);
                n++;
            end
        end
        exp_last = exp_strobe[DATA_NUM-1];
        exp_done = exp_last + PIPE_LAT;
        if (hold_mode == 2) reload_off = exp_strobe[$urandom_range(1000, 10)];

        for (int off = first_off; off <= exp_done + 2; off++) begin
            i_sym_req      = (off == 0);
            i_entry_select = entry;
            i_hold         = hold_pat[off];
            i_reload       = (off == reload_off);
            to_sample();
            if (o_data_valid === 1'b1)  got_strobe.push_back(off);
            if (o_data_last === 1'b1)   got_last.push_back(off);
            if (o_phase_valid === 1'b1) got_pv.push_back(off);
            if (o_phase_last === 1'b1)  got_pl.push_back(off);
            if (o_done === 1'b1)        got_done.push_back(off);
            if (o_start === 1'b1)       got_start.push_back(off);
            if (o_sym_ack === 1'b1)     got_ack.push_back(off);
            exp_ena = (off >= 1) && (off <= exp_done);
            if (o_ram_ena !== exp_ena) bad_ena++;
            if (o_ram_wena !== 1'b0) bad_wena++;
            if (o_cfg_ready !== 1'b0) bad_ready++;
            if (off >= 1 && o_entry_select !== entry) bad_entry++;
            to_drive();
        end
        i_sym_req = 1'b0;
        i_hold    = 1'b0;
        i_reload  = 1'b0;

        for (int i = 0; i < DATA_NUM; i++) begin
            if (i >= got_strobe.size() || got_strobe[i] != exp_strobe[i]) begin
                bad_seq = i;
                break;
            end
        end
        for (int i = 0; i < DATA_NUM; i++) begin
            if (i >= got_pv.size() || got_pv[i] != exp_strobe[i] + PIPE_LAT) begin
                bad_pv = i;
                break;
            end
        end
        check({tag, "_ack_count"}, 64'(got_ack.size()), 1);
        check({tag, "_ack_at"}, 64'(first_or_neg(got_ack)), 1);
        check({tag, "_start_count"}, 64'(got_start.size()), 1);
        check({tag, "_start_at"}, 64'(first_or_neg(got_start)), 1);
        check({tag, "_strobe_count"}, 64'(got_strobe.size()), 64'(DATA_NUM));
        check({tag, "_strobe_first_bad"}, 64'(bad_seq), -64'sd1);
        check({tag, "_last_count"}, 64'(got_last.size()), 1);
        check({tag, "_last_at"}, 64'(first_or_neg(got_last)), 64'(exp_last));
        if (hold_mode != 2)
            check({tag, "_last_abs"}, 64'(first_or_neg(got_last)),
                  64'(FIRST_STROBE_OFF + DATA_NUM - 1 + ((hold_mode == 1) ? 10 : 0)));
        check({tag, "_phase_valid_count"}, 64'(got_pv.size()), 64'(DATA_NUM));
        check({tag, "_phase_valid_first_bad"}, 64'(bad_pv), -64'sd1);
        check({tag, "_phase_last_at"}, 64'(first_or_neg(got_pl)), 64'(exp_last + PIPE_LAT));
        check({tag, "_done_count"}, 64'(got_done.size()), 1);
        check({tag, "_done_at"}, 64'(first_or_neg(got_done)), 64'(exp_done));
        check({tag, "_ram_ena_bad"}, 64'(bad_ena), 0);
        check({tag, "_ram_wena_bad"}, 64'(bad_wena), 0);
        check({tag, "_cfg_ready_bad"}, 64'(bad_ready), 0);
        check({tag, "_entry_bad"}, 64'(bad_entry), 0);
    endtask

    // Reset asserted in the cycle of the 300th strobe of an un-held symbol.
    task automatic reset_mid_symbol();
        int strobes = 0;
        int pv_after = 0;
        int r_off = FIRST_STROBE_OFF + 299;
        for (int off = 0; off <= r_off; off++) begin
            i_sym_req      = (off == 0);
            i_entry_select = 6'd9;
            i_hold         = 1'b0;
            if (off == r_off) rst_n = 1'b0;
            to_sample();
            if (o_data_valid === 1'b1) strobes++;
            to_drive();
        end
        check("rst_strobes_before", 64'(strobes), 300);
        rst_n = 1'b1;
        to_sample();
        check("rst_ctrl_outputs_zero", ctrl_outs(), 0);
        check("rst_ram_dina_zero", o_ram_dina, 0);
        to_drive();
        to_sample();
        check("rst_back_in_load_ready", 64'(o_cfg_ready), 1);
        check("rst_load_done_cleared", 64'(o_load_done), 0);
        to_drive();
        for (int i = 0; i < PIPE_LAT + 2; i++) begin
            to_sample();
            if (o_phase_valid !== 1'b0 || o_done !== 1'b0) pv_after++;
            to_drive();
        end
        check("rst_delay_line_flushed", 64'(pv_after), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        load_vec_t lv[6];
        lv[0] = '{n_words: 136, last_idx: 135, pre_reload: 1'b0, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
        lv[1] = '{n_words: 101, last_idx: 100, pre_reload: 1'b1, gaps: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
        lv[2] = '{n_words: 136, last_idx: 135, pre_reload: 1'b0, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
        lv[3] = '{n_words: 136, last_idx: -1,  pre_reload: 1'b1, gaps: 1'b1, exp_done: 1'b0, exp_err: 1'b1};
        lv[4] = '{n_words: 1,   last_idx: 0,   pre_reload: 1'b0, gaps: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
        lv[5] = '{n_words: 136, last_idx: 135, pre_reload: 1'b0, gaps: 1'b1, exp_done: 1'b1, exp_err: 1'b0};

        // Reset state, then one IDLE cycle before LOAD.
        rst_n = 1'b0;
        repeat (3) to_drive();
        to_sample();
        check("reset_ctrl_outputs_zero", ctrl_outs(), 0);
        check("reset_ram_dina_zero", o_ram_dina, 0);
        to_drive();
        rst_n = 1'b1;
        to_sample();
        check("idle_cfg_ready", 64'(o_cfg_ready), 0);
        to_drive();
        to_sample();
        check("load_cfg_ready", 64'(o_cfg_ready), 1);
        check("load_done_initial", 64'(o_load_done), 0);
        to_drive();

        foreach (lv[k]) begin
            load_table(lv[k].n_words, lv[k].last_idx, lv[k].pre_reload, lv[k].gaps,
                       lv[k].exp_done, lv[k].exp_err, $sformatf("load%0d", k));
        end

        run_symbol(6'd5, 0, 0, "sym_e5");
        run_symbol(6'd17, 0, 1, "sym_hold500");
        for (int k = 0; k < 3; k++)
            run_symbol(ENTRY_SEL_WIDTH'($urandom), 0, 2, $sformatf("sym_rand%0d", k));

        // Reload and request together in READY: the reload wins and the
        // request stays pending until the new table is in.
        i_entry_select = 6'd33;
        i_sym_req      = 1'b1;
        load_table(136, 135, 1'b1, 1'b0, 1'b1, 1'b0, "reload_req");
        run_symbol(6'd33, 1, 0, "after_reload");

        reset_mid_symbol();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
